vec_dot_mac: RTL and testbench
==============================

Name: vec_dot_mac

Overview:
- Parametrised successor to the single-lane vector multiply-accumulate PE.
- Computes the signed dot product of two C-element vectors using L parallel multipliers per cycle.
- Provides valid/ready handshakes on input and output, plus a selectable output stage: truncate, shift-saturate, or shift-round-saturate.
- Sits in the Processing Element between the vector operand buffers and the result writeback path.

Parameters:
- C, 8, vector element count (>=1).
- L, 2, multiplier lanes per cycle (1..C).
- W_X, 8, signed width of x elements.
- W_K, 8, signed width of k elements.
- W_O, 8, signed width of output y.
- Derived localparams: W_M=W_X+W_K; W_Y=W_M+max(1,$clog2(C)); NB=ceil(C/L) beats; W_S=$clog2(W_Y).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  operand vector valid.
- s_ready  out  1  block can accept operands.
- k  in  [C-1:0][W_K-1:0]  signed vector 1.
- x  in  [C-1:0][W_X-1:0]  signed vector 2.
- mode  in  2  00 truncate, 01 shift+saturate, 10 shift+round+saturate, 11 treated as 01.
- shift  in  W_S  arithmetic right-shift amount applied before saturation.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- y  out  W_O  post-processed signed result.
- ovf  out  1  saturation occurred for this result.
- acc  out  W_Y  full-precision signed sum, unmodified.

Behaviour:
- Reset (rst_n low, any state): state=IDLE, m_valid=0, y=0, ovf=0, acc=0, beat counter=0, internal accumulator=0. Reset takes effect immediately; any in-flight vector is discarded.
- s_ready = (state==IDLE), combinational; it is high during reset.
- IDLE: on an edge with s_valid&&s_ready, register k, x, mode, shift, clear the accumulator, set beat=0, and go to RUN. k/x changes after acceptance have no effect.
- RUN: each edge adds the sum of L products for elements beat*L..beat*L+L-1. Indices >=C contribute 0 (zero padding). Products are full W_M signed; the accumulator is W_Y and cannot overflow. beat increments each edge. On the edge where beat==NB-1, the final partial sum is added and the state goes to POST.
- POST: one edge computes y/ovf from the final sum and latches acc, then sets m_valid=1 and goes to OUT.
- Latency: the acceptance edge is edge 0; m_valid is high after edge NB+1.
- OUT: m_valid=1; y, ovf and acc are held stable while m_ready=0, for unbounded backpressure. On an edge with m_ready=1, m_valid goes to 0 and the state returns to IDLE. s_valid is ignored outside IDLE.
- Mode 00: y = acc[W_O-1:0]; ovf=0; shift is ignored.
- Mode 01: v = acc >>> shift (sign-preserving). If v > 2^(W_O-1)-1, y = max and ovf=1. If v < -2^(W_O-1), y = min and ovf=1. Otherwise y = v and ovf=0.
- Mode 10: same as 01, except v = (acc + 2^(shift-1)) >>> shift when shift>0 (round half up). Use a W_Y+1 intermediate so no internal overflow occurs. shift==0 behaves as mode 01.
- shift >= W_Y: v = 0 for a non-negative acc, -1 for a negative acc.
- Edge cases: C=1 gives NB=1. L=C gives a single-beat dot product.

Test Plan:
- C=8,L=2, x={1..8}, k=all 1, mode 00 -> y=36, acc=36, ovf=0; m_valid rises exactly after edge 5; s_ready low from edge 0 until the result handshakes.
- x=all 127, k=all 127: mode 01, shift 0 -> acc=129032, y=127, ovf=1; same operands with mode 00 -> y=8 (0x1F808 low byte), ovf=0.
- x=all -128, k=all 127, mode 01, shift 10 -> acc=-130048, y=-127, ovf=0. Same with shift 0 -> y=-128, ovf=1.
- Sum 36 with shift 3: mode 01 -> y=4; mode 10 -> y=5. Sum -36 with shift 3: mode 10 -> y=-4.
- Result present with m_ready=0 for 10 cycles: y/acc/ovf stable, s_ready=0, pulsing s_valid has no effect; m_ready=1 -> m_valid falls and s_ready rises on the next edge.
- C=5,L=2, x={1,2,3,4,5}, k={1,1,1,1,1}: NB=3, padding correct -> acc=15, m_valid after edge 4.
- Reset during RUN: assert rst_n low at beat 1 -> outputs immediately 0, s_ready=1. The next vector x={1..8}, k=all 1 yields exactly 36, with no residue from the aborted vector.

Source files
------------

// File: rtl/vec_dot_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_dot_mac : L-lane signed dot product of two C-element vectors with a
//               valid/ready interface and a truncate/saturate/round output stage.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module vec_dot_mac #(
  parameter int C   = 8,
  parameter int L   = 2,
  parameter int W_X = 8,
  parameter int W_K = 8,
  parameter int W_O = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [C-1:0][W_K-1:0]        k,
  input  logic [C-1:0][W_X-1:0]        x,
  input  logic [1:0]                   mode,
  input  logic [$clog2(W_X+W_K+(($clog2(C) > 1) ? $clog2(C) : 1))-1:0] shift,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [W_O-1:0]               y,
  output logic                         ovf,
  output logic [W_X+W_K+(($clog2(C) > 1) ? $clog2(C) : 1)-1:0] acc
);
  localparam int W_M = W_X + W_K;
  localparam int W_Y = W_M + (($clog2(C) > 1) ? $clog2(C) : 1);
  localparam int NB  = (C + L - 1) / L;
  localparam int W_S = $clog2(W_Y);
  localparam int W_B = (NB > 1) ? $clog2(NB) : 1;

  localparam logic signed [W_Y:0]  V_MAX = (W_Y+1)'((1 <<< (W_O-1)) - 1);
  localparam logic signed [W_Y:0]  V_MIN = ~V_MAX;
  localparam logic [W_O-1:0]       Y_MAX = {1'b0, {(W_O-1){1'b1}}};
  localparam logic [W_O-1:0]       Y_MIN = {1'b1, {(W_O-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_POST, S_OUT} state_t;

  state_t                  r_state;
  logic [C-1:0][W_K-1:0]   r_k;
  logic [C-1:0][W_X-1:0]   r_x;
  logic [1:0]              r_mode;
  logic [W_S-1:0]          r_shift;
  logic [W_B-1:0]          r_beat;
  logic signed [W_Y-1:0]   r_sum;

  logic signed [W_M-1:0]   w_prod;
  logic signed [W_Y-1:0]   w_part;
  logic signed [W_Y:0]     w_ext;
  logic signed [W_Y:0]     w_rnd;
  logic signed [W_Y:0]     w_v;
  logic [W_O-1:0]          w_y;
  logic                    w_ovf;

  assign s_ready = (r_state == S_IDLE);

  // Elements outside the current beat (including padding past C) are masked out.
  always_comb begin
    w_part = '0;
    w_prod = '0;
    for (int i = 0; i < C; i++) begin
      if (r_beat == W_B'(i / L)) begin
        w_prod = W_M'($signed(r_k[i])) * W_M'($signed(r_x[i]));
        w_part = w_part + W_Y'(w_prod);
      end
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    w_ext = {r_sum[W_Y-1], r_sum};
    w_rnd = '0;
    if (r_mode == 2'b10 && r_shift != '0)
      w_rnd = (W_Y+1)'(1) << (r_shift - W_S'(1));
    if (int'(r_shift) >= W_Y)
      w_v = {(W_Y+1){r_sum[W_Y-1]}};
    else
      w_v = (w_ext + w_rnd) >>> r_shift;

    w_y   = w_v[W_O-1:0];
    w_ovf = 1'b0;
    if (r_mode == 2'b00) begin
      w_y = r_sum[W_O-1:0];
    end else if (w_v > V_MAX) begin
      w_y   = Y_MAX;
      w_ovf = 1'b1;
    end else if (w_v < V_MIN) begin
      w_y   = Y_MIN;
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_x     <= '0;
      r_mode  <= '0;
      r_shift <= '0;
      r_beat  <= '0;
      r_sum   <= '0;
      m_valid <= 1'b0;
      y       <= '0;
      ovf     <= 1'b0;
      acc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            r_k     <= k;
            r_x     <= x;
            r_mode  <= mode;
            r_shift <= shift;
            r_beat  <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum <= r_sum + w_part;
          if (r_beat == W_B'(NB - 1))
            r_state <= S_POST;
          else
            r_beat <= r_beat + W_B'(1);
        end
        S_POST: begin
          y       <= w_y;
          ovf     <= w_ovf;
          acc     <= r_sum;
          m_valid <= 1'b1;
          r_state <= S_OUT;
        end
        default: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vec_dot_mac.sv
`default_nettype none
// Bench for vec_dot_mac: directed test-plan vectors plus random vectors checked
// against an arithmetic reference model; a second instance covers C=5 padding.
module tb_vec_dot_mac;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic [7:0][7:0]   k = '0;
  logic [7:0][7:0]   x = '0;
  logic [1:0]        mode = '0;
  logic [4:0]        shift = '0;
  logic              s_ready, m_valid, ovf;
  logic [7:0]        y;
  logic [18:0]       acc;

  logic              s_valid5 = 1'b0;
  logic              m_ready5 = 1'b0;
  logic              s_ready5, m_valid5, ovf5;
  logic [7:0]        y5;
  logic [18:0]       acc5;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0][7:0] kv, xv;

  always #5 clk = ~clk;

  vec_dot_mac #(.C(8), .L(2), .W_X(8), .W_K(8), .W_O(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .k(k), .x(x), .mode(mode), .shift(shift),
    .m_valid(m_valid), .m_ready(m_ready), .y(y), .ovf(ovf), .acc(acc)
  );

  vec_dot_mac #(.C(5), .L(2), .W_X(8), .W_K(8), .W_O(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid5), .s_ready(s_ready5),
    .k(k[4:0]), .x(x[4:0]), .mode(mode), .shift(shift),
    .m_valid(m_valid5), .m_ready(m_ready5), .y(y5), .ovf(ovf5), .acc(acc5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer dot product, floor division for the shift.
  function automatic void model(input logic [7:0][7:0] kk, input logic [7:0][7:0] xx,
                                input logic [1:0] md, input logic [4:0] sh, input int c,
                                output longint a, output int yv, output bit ov);
    longint d, num, v;
    a = 0;
    for (int i = 0; i < c; i++)
      a += longint'($signed(kk[i])) * longint'($signed(xx[i]));
    ov = 1'b0;
    if (md == 2'b00) begin
      yv = int'($signed(a[7:0]));
    end else begin
      if (sh >= 19) begin
        v = (a < 0) ? -1 : 0;
      end else begin
        d   = longint'(1) << sh;
        num = a + ((md == 2'b10 && sh != 0) ? d / 2 : 0);
        v   = (num >= 0) ? num / d : -((-num + d - 1) / d);
      end
      if (v > 127) begin
        yv = 127; ov = 1'b1;
      end else if (v < -128) begin
        yv = -128; ov = 1'b1;
      end else begin
        yv = int'(v);
      end
    end
  endfunction

  task automatic do_vec(input logic [7:0][7:0] kk, input logic [7:0][7:0] xx,
                        input logic [1:0] md, input logic [4:0] sh, input int hold,
                        input string tag);
    longint ea;
    int ey, cnt;
    bit eo, sr_bad;
    logic [7:0] ey8;
    logic [18:0] ea19;
    model(kk, xx, md, sh, 8, ea, ey, eo);
    ey8  = 8'(ey);
    ea19 = 19'(ea);
    k = kk; x = xx; mode = md; shift = sh; s_valid = 1'b1;
    chk({tag, ".s_ready_idle"}, 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    k = {$urandom, $urandom}; x = {$urandom, $urandom};
    mode = 2'($urandom); shift = 5'($urandom);
    cnt = 0; sr_bad = 1'b0;
    while (!m_valid && cnt < 20) begin
      if (s_ready) sr_bad = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".latency"}, 64'(cnt), 64'(NB + 1));
    chk({tag, ".s_ready_busy"}, 64'(sr_bad | s_ready), 64'(0));
    chk({tag, ".y"}, 64'(y), 64'(ey8));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ".acc"}, 64'(acc), 64'(ea19));
    for (int i = 0; i < hold; i++) begin
      s_valid = i[0];
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 64'(m_valid), 64'(1));
      chk({tag, ".hold_y"}, 64'(y), 64'(ey8));
      chk({tag, ".hold_acc"}, 64'(acc), 64'(ea19));
      chk({tag, ".hold_s_ready"}, 64'(s_ready), 64'(0));
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk({tag, ".m_valid_drop"}, 64'(m_valid), 64'(0));
    chk({tag, ".s_ready_back"}, 64'(s_ready), 64'(1));
  endtask

  initial begin
    int cnt;
    #2;
    chk("rst.s_ready", 64'(s_ready), 64'(1));
    chk("rst.m_valid", 64'(m_valid), 64'(0));
    chk("rst.y", 64'(y), 64'(0));
    chk("rst.ovf", 64'(ovf), 64'(0));
    chk("rst.acc", 64'(acc), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin kv[i] = 8'd1; xv[i] = 8'(i + 1); end
    do_vec(kv, xv, 2'b00, 5'd0, 0, "sum36_trunc");
    do_vec(kv, xv, 2'b01, 5'd3, 0, "sum36_sh3_sat");
    do_vec(kv, xv, 2'b10, 5'd3, 0, "sum36_sh3_rnd");
    for (int i = 0; i < 8; i++) xv[i] = 8'(-(i + 1));
    do_vec(kv, xv, 2'b10, 5'd3, 0, "summ36_sh3_rnd");

    for (int i = 0; i < 8; i++) begin kv[i] = 8'd127; xv[i] = 8'd127; end
    do_vec(kv, xv, 2'b01, 5'd0, 0, "max_sat");
    do_vec(kv, xv, 2'b00, 5'd0, 0, "max_trunc");
    for (int i = 0; i < 8; i++) xv[i] = 8'h80;
    do_vec(kv, xv, 2'b01, 5'd10, 0, "neg_sh10");
    do_vec(kv, xv, 2'b01, 5'd0, 0, "neg_sat");
    do_vec(kv, xv, 2'b10, 5'd25, 0, "neg_bigshift");

    for (int i = 0; i < 8; i++) begin kv[i] = 8'd1; xv[i] = 8'(i + 1); end
    do_vec(kv, xv, 2'b11, 5'd2, 10, "backpressure");

    // Abort a vector mid-run; the next one must show no residue.
    for (int i = 0; i < 8; i++) begin kv[i] = 8'($urandom); xv[i] = 8'($urandom); end
    k = kv; x = xv; mode = 2'b00; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.m_valid", 64'(m_valid), 64'(0));
    chk("midrst.y", 64'(y), 64'(0));
    chk("midrst.acc", 64'(acc), 64'(0));
    chk("midrst.ovf", 64'(ovf), 64'(0));
    chk("midrst.s_ready", 64'(s_ready), 64'(1));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin kv[i] = 8'd1; xv[i] = 8'(i + 1); end
    do_vec(kv, xv, 2'b00, 5'd0, 0, "post_rst");

    // Five-element instance: three beats with one padded lane.
    for (int i = 0; i < 8; i++) begin k[i] = 8'd1; x[i] = (i < 5) ? 8'(i + 1) : 8'd99; end
    mode = 2'b00; shift = '0; s_valid5 = 1'b1;
    @(posedge clk); #1;
    s_valid5 = 1'b0;
    k = '0; x = '0;
    cnt = 0;
    while (!m_valid5 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("c5.latency", 64'(cnt), 64'(4));
    chk("c5.acc", 64'(acc5), 64'(15));
    chk("c5.y", 64'(y5), 64'(15));
    chk("c5.ovf", 64'(ovf5), 64'(0));
    m_ready5 = 1'b1;
    @(posedge clk); #1;
    m_ready5 = 1'b0;
    chk("c5.m_valid_drop", 64'(m_valid5), 64'(0));

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 8; i++) begin kv[i] = 8'($urandom); xv[i] = 8'($urandom); end
      do_vec(kv, xv, 2'($urandom), 5'($urandom), int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
